// File: rtl/lfsr_axi_pkg.sv
// Shared definitions for the LFSR AXI-Lite initiator: register map, CTRL bits,
// response codes and the sequencer state encoding.
// No logic; imported by lfsr_axi_master and axi_lite_wr_chan.
package lfsr_axi_pkg;

   // Slave register map (byte addresses)
   localparam logic [7:0] REG_CTRL = 8'h0;
   localparam logic [7:0] REG_SEED = 8'h4;
   localparam logic [7:0] REG_TAPS = 8'h8;
   localparam logic [7:0] REG_DATA = 8'hC;

   // CTRL register fields
   localparam int CTRL_EN_BIT   = 0;
   localparam int CTRL_LOAD_BIT = 1;
   localparam logic [7:0] CTRL_EN   = 8'(1 << CTRL_EN_BIT);
   localparam logic [7:0] CTRL_LOAD = 8'(1 << CTRL_LOAD_BIT);

   localparam logic [1:0] RESP_OKAY = 2'b00;

   typedef enum logic [2:0] {
      ST_IDLE, ST_WR_REQ, ST_WR_RESP, ST_RD_REQ, ST_RD_RESP, ST_OUT, ST_DONE
   } state_t;

   // Order matters: the sequencer walks these by incrementing.
   typedef enum logic [2:0] {
      WR_SEED, WR_TAPS, WR_LOAD, WR_EN, WR_STOP
   } wr_step_t;

endpackage

// File: rtl/axi_lite_wr_chan.sv
// One AXI-Lite write: AW and W raised together while go is high, each held
// until its own ready; B accepted while resp_en is high.
// Latency: accepted in the cycle the later of awready/wready is seen.
// Backpressure: valids and addr/data held indefinitely until ready.
// Ports: go/resp_en/addr/data from the sequencer; accepted/done/resp back;
// m_axi_aw*/w*/b* to the slave.
module axi_lite_wr_chan
   import lfsr_axi_pkg::*;
#(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  go,
   input  logic                  resp_en,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] data,
   output logic                  accepted,
   output logic                  done,
   output logic [1:0]            resp,
   output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
   output logic                  m_axi_awvalid,
   input  logic                  m_axi_awready,
   output logic [DATA_WIDTH-1:0] m_axi_wdata,
   output logic                  m_axi_wvalid,
   input  logic                  m_axi_wready,
   input  logic [1:0]            m_axi_bresp,
   input  logic                  m_axi_bvalid,
   output logic                  m_axi_bready
);

   logic aw_done;
   logic w_done;

   assign m_axi_awvalid = go && !aw_done;
   assign m_axi_wvalid  = go && !w_done;
   // Drive zero when idle so the bus is quiet outside a write.
   assign m_axi_awaddr  = go ? addr : '0;
   assign m_axi_wdata   = go ? data : '0;
   assign m_axi_bready  = resp_en;

   // Either channel may have completed in an earlier cycle or complete now.
   assign accepted = go && (aw_done || m_axi_awready) && (w_done || m_axi_wready);
   assign done     = resp_en && m_axi_bvalid;
   assign resp     = m_axi_bresp;

   always_ff @(posedge clk) begin
      if (!resetn || !go || accepted) begin
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else begin
         if (m_axi_awready) aw_done <= 1'b1;
         if (m_axi_wready)  w_done  <= 1'b1;
      end
   end

endmodule

// File: rtl/lfsr_axi_master.sv
// AXI-Lite initiator: programs SEED/TAPS/CTRL of an LFSR slave, reads DATA
// cfg_count times onto a byte stream, disables the LFSR and pulses done.
// Latency: 2 cycles/write, 3 cycles/sample minimum; awvalid 1 cycle after start.
// Backpressure: a pending sample (sample_ready low) stalls all AXI traffic.
module lfsr_axi_master
   import lfsr_axi_pkg::*;
#(
   parameter int ADDR_WIDTH  = 4,
   parameter int DATA_WIDTH  = 8,
   parameter int COUNT_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   start,
   input  logic [7:0]             cfg_seed,
   input  logic [7:0]             cfg_taps,
   input  logic [COUNT_WIDTH-1:0] cfg_count,
   output logic                   busy,
   output logic                   done,
   output logic                   error,
   output logic [7:0]             sample_data,
   output logic                   sample_valid,
   input  logic                   sample_ready,
   output logic [ADDR_WIDTH-1:0]  m_axi_awaddr,
   output logic                   m_axi_awvalid,
   input  logic                   m_axi_awready,
   output logic [DATA_WIDTH-1:0]  m_axi_wdata,
   output logic                   m_axi_wvalid,
   input  logic                   m_axi_wready,
   input  logic [1:0]             m_axi_bresp,
   input  logic                   m_axi_bvalid,
   output logic                   m_axi_bready,
   output logic [ADDR_WIDTH-1:0]  m_axi_araddr,
   output logic                   m_axi_arvalid,
   input  logic                   m_axi_arready,
   input  logic [DATA_WIDTH-1:0]  m_axi_rdata,
   input  logic [1:0]             m_axi_rresp,
   input  logic                   m_axi_rvalid,
   output logic                   m_axi_rready
);

   state_t                 state, state_n;
   wr_step_t               wr_step;
   logic [7:0]             seed_q, taps_q, sample_q;
   logic [COUNT_WIDTH-1:0] remain_q;
   logic                   error_q;

   logic                   wr_go, wr_resp_en, wr_accepted, wr_done;
   logic [1:0]             wr_resp;
   logic [ADDR_WIDTH-1:0]  wr_addr;
   logic [DATA_WIDTH-1:0]  wr_data;

   assign error       = error_q;
   assign sample_data = sample_q;

   always_comb begin
      wr_addr = ADDR_WIDTH'(REG_CTRL);
      wr_data = '0;
      case (wr_step)
         WR_SEED: begin wr_addr = ADDR_WIDTH'(REG_SEED); wr_data = DATA_WIDTH'(seed_q); end
         WR_TAPS: begin wr_addr = ADDR_WIDTH'(REG_TAPS); wr_data = DATA_WIDTH'(taps_q); end
         WR_LOAD: wr_data = DATA_WIDTH'(CTRL_LOAD);
         WR_EN:   wr_data = DATA_WIDTH'(CTRL_EN);
         default: wr_data = '0;
      endcase
   end

   axi_lite_wr_chan #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_wr (
      .clk(clk), .resetn(resetn), .go(wr_go), .resp_en(wr_resp_en),
      .addr(wr_addr), .data(wr_data), .accepted(wr_accepted), .done(wr_done), .resp(wr_resp),
      .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
      .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
   );

   always_ff @(posedge clk) begin
      if (!resetn) state <= ST_IDLE;
      else         state <= state_n;
   end

   always_comb begin
      state_n       = state;
      busy          = 1'b1;
      done          = 1'b0;
      wr_go         = 1'b0;
      wr_resp_en    = 1'b0;
      m_axi_arvalid = 1'b0;
      m_axi_araddr  = '0;
      m_axi_rready  = 1'b0;
      sample_valid  = 1'b0;
      case (state)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) state_n = ST_WR_REQ;
         end
         ST_WR_REQ: begin
            wr_go = 1'b1;
            if (wr_accepted) state_n = ST_WR_RESP;
         end
         ST_WR_RESP: begin
            wr_resp_en = 1'b1;
            if (wr_done) begin
               // An error response abandons the sequence, including the stop write.
               if (wr_resp != RESP_OKAY || wr_step == WR_STOP) state_n = ST_DONE;
               else if (wr_step == WR_EN && remain_q != '0)    state_n = ST_RD_REQ;
               else                                            state_n = ST_WR_REQ;
            end
         end
         ST_RD_REQ: begin
            m_axi_arvalid = 1'b1;
            m_axi_araddr  = ADDR_WIDTH'(REG_DATA);
            if (m_axi_arready) state_n = ST_RD_RESP;
         end
         ST_RD_RESP: begin
            m_axi_rready = 1'b1;
            if (m_axi_rvalid) state_n = (m_axi_rresp != RESP_OKAY) ? ST_WR_REQ : ST_OUT;
         end
         ST_OUT: begin
            sample_valid = 1'b1;
            if (sample_ready) state_n = (remain_q == COUNT_WIDTH'(1)) ? ST_WR_REQ : ST_RD_REQ;
         end
         ST_DONE: begin
            busy    = 1'b0;
            done    = 1'b1;
            state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_step  <= WR_SEED;
         seed_q   <= '0;
         taps_q   <= '0;
         remain_q <= '0;
         sample_q <= '0;
         error_q  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: if (start) begin
               seed_q   <= cfg_seed;
               taps_q   <= cfg_taps;
               remain_q <= cfg_count;
               error_q  <= 1'b0;
               wr_step  <= WR_SEED;
            end
            // After WR_EN the step sits at WR_STOP, so both the end of the
            // read loop and a read error fall straight into the stop write.
            ST_WR_RESP: if (wr_done) begin
               if (wr_resp != RESP_OKAY)  error_q <= 1'b1;
               else if (wr_step != WR_STOP) wr_step <= wr_step_t'(wr_step + 3'd1);
            end
            ST_RD_RESP: if (m_axi_rvalid) begin
               sample_q <= 8'(m_axi_rdata);
               if (m_axi_rresp != RESP_OKAY) error_q <= 1'b1;
            end
            ST_OUT: if (sample_ready) remain_q <= remain_q - COUNT_WIDTH'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: doc/lfsr_axi_master.md
Name: lfsr_axi_master

Overview:
AXI-Lite initiator that programs and drains an lfsr_axi_top instance, so software-free test and bring-up paths can generate pseudo-random bytes. On a start request it writes seed, taps and control registers, then issues a programmed number of reads of the LFSR data register. Each read result is forwarded on a valid/ready byte stream. It finishes by disabling the LFSR and pulsing done.

Parameters:
ADDR_WIDTH, 4, AXI-Lite address width; must match the slave.
DATA_WIDTH, 8, AXI-Lite data width; must match the slave.
COUNT_WIDTH, 8, width of the sample-count request.

Ports:
clk  in  1  system clock, all logic on rising edge
resetn  in  1  synchronous active-low reset
start  in  1  one-cycle request; sampled only in IDLE
cfg_seed  in  8  seed value, captured on accepted start
cfg_taps  in  8  tap mask, captured on accepted start
cfg_count  in  COUNT_WIDTH  number of LFSR reads, captured on accepted start
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse at sequence end
error  out  1  sticky; set on a non-OKAY bresp or rresp; cleared by the next accepted start
sample_data  out  8  read LFSR byte
sample_valid  out  1  stream valid
sample_ready  in  1  stream ready
m_axi_awaddr  out  ADDR_WIDTH  write address
m_axi_awvalid  out  1  write address valid
m_axi_awready  in  1  write address ready
m_axi_wdata  out  DATA_WIDTH  write data
m_axi_wvalid  out  1  write data valid
m_axi_wready  in  1  write data ready
m_axi_bresp  in  2  write response
m_axi_bvalid  in  1  write response valid
m_axi_bready  out  1  write response ready
m_axi_araddr  out  ADDR_WIDTH  read address
m_axi_arvalid  out  1  read address valid
m_axi_arready  in  1  read address ready
m_axi_rdata  in  DATA_WIDTH  read data
m_axi_rresp  in  2  read response
m_axi_rvalid  in  1  read data valid
m_axi_rready  out  1  read data ready

Behaviour:
- Register map: CTRL=0x0 (bit0 enable, bit1 load), SEED=0x4, TAPS=0x8, DATA=0xC.
- Reset: every output is 0, error is cleared, state is IDLE. Reset asserted mid-transaction drops all valids at that edge. No completion of the outstanding transaction is attempted.
- Write sequence after start: SEED=cfg_seed, TAPS=cfg_taps, CTRL=0x02, CTRL=0x01.
- Read loop: cfg_count reads of DATA.
- Stop: CTRL=0x00, then DONE.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, OUT, DONE.
- WR_REQ:
  - awvalid and wvalid are asserted together in the same cycle.
  - Each valid is held until its own ready is seen. Per-channel flags aw_done and w_done track this.
  - Address and data are stable while the valid is high.
  - When both flags are set, go to WR_RESP.
  - Same-cycle acceptance of both channels goes to WR_RESP on the next cycle.
- WR_RESP: bready=1. On bvalid:
  - bresp!=0: set error and jump to DONE. The stop write is skipped.
  - bresp==0: advance to the next write. After CTRL=0x01, go to RD_REQ, or to the stop write if cfg_count==0. After the stop write, go to DONE.
- RD_REQ: arvalid held with araddr=0xC until arready, then go to RD_RESP.
- RD_RESP: rready=1. On rvalid:
  - Capture rdata into sample_data.
  - rresp!=0: set error and go to the stop write; no sample is emitted.
  - rresp==0: go to OUT.
- OUT:
  - sample_valid=1, with sample_data stable until sample_ready.
  - On handshake, decrement the remaining count.
  - If the count is nonzero, go to RD_REQ; otherwise go to the stop write.
  - No new read is issued while a sample is pending; backpressure stalls the AXI side.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- Latency:
  - Minimum of 2 cycles per write with zero-wait ready (REQ, RESP).
  - Minimum of 3 cycles per sample (RD_REQ, RD_RESP, OUT).
  - start to first awvalid is 1 cycle.
- start while busy is ignored, and the captured config is unchanged.
- cfg_count is unsigned. The maximum count 2^COUNT_WIDTH-1 reads exactly that many; there is no wrap.
- At most one transaction is outstanding at a time. Read and write channels are never active simultaneously.

Decomposition:
- Package lfsr_axi_pkg holds:
  - register address constants CTRL/SEED/TAPS/DATA;
  - CTRL bit positions;
  - the RESP_OKAY constant;
  - the state enum.
- Single sub-module axi_lite_wr_chan: drives the AW/W/B handshake for one write (addr, data, go in; done, resp out). It is reused for all five writes.
- The read path stays inline.

Test Plan:
- Zero-wait slave (lfsr_axi_top), seed=0x5A, taps=0xB8, count=3 -> writes to 0x4,0x8,0x0(0x02),0x0(0x01), three reads of 0xC, final write 0x0=0x00, then done pulse. Samples match the LFSR reference model, and error=0.
- Slave with awready delayed 3 cycles and wready immediate (then reversed) -> each valid is held independently, a single write completes per register, and addr/data are stable while valid.
- bresp=SLVERR on the TAPS write -> error=1, no further AW or AR issued, done pulses, busy falls. The next start clears error.
- sample_ready low for 5 cycles on the second sample -> sample_valid/data held, no arvalid during the stall, and the total of 3 samples is unchanged.
- count=0 -> four config writes plus the stop write, no AR traffic, no sample_valid, done pulse.
- resetn driven low while arvalid is high mid-loop -> all outputs 0 at the next edge, IDLE. A new start runs the full sequence correctly.
